c4_sched_ctrl: RTL and testbench

Multi-cycle controller that computes the circuit4 dataflow (d/e/f add-sub, compare, select, shift) by time-sharing one add/sub unit and one comparator under FSM control. Replaces the fully parallel datapath where area matters. Upstream issues a start pulse with operands a/b/c. The block returns registered x/z with a one-cycle done pulse.

---
 rtl/c4_sched_ctrl_if.sv | 24 ++
 rtl/c4_sched_ctrl.sv | 124 ++++++++++++
 tb/tb_c4_sched_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/c4_sched_ctrl_if.sv
// rtl/c4_sched_ctrl_if.sv - request/result bundle between an issuer and c4_sched_ctrl
interface c4_sched_ctrl_if #(
    parameter int DATAWIDTH = 64,
    parameter int OUTWIDTH  = 32
);
    logic                 start;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] c;
    logic                 busy;
    logic                 done;
    logic [OUTWIDTH-1:0]  x;
    logic [OUTWIDTH-1:0]  z;

    modport master (
        output start, a, b, c,
        input  busy, done, x, z
    );

    modport slave (
        input  start, a, b, c,
        output busy, done, x, z
    );
endinterface

// File: rtl/c4_sched_ctrl.sv
// rtl/c4_sched_ctrl.sv - circuit4 dataflow sequenced over one shared add/sub unit and one comparator
module c4_sched_ctrl #(
    parameter int DATAWIDTH = 64,
    parameter int OUTWIDTH  = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    c4_sched_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC_D = 3'd1,
        CALC_E = 3'd2,
        CALC_F = 3'd3,
        SEL    = 3'd4,
        SHIFT  = 3'd5
    } state_t;

    state_t               state_q;
    logic [DATAWIDTH-1:0] a_q, b_q, c_q;
    logic [DATAWIDTH-1:0] d_q, e_q, f_q, g_q, h_q;
    logic                 lt_q, eq_q;
    logic                 busy_q, done_q;
    logic [OUTWIDTH-1:0]  x_q, z_q;

    logic [DATAWIDTH-1:0] alu_b;
    logic                 alu_sub;
    logic [DATAWIDTH-1:0] alu_res_d;
    logic                 cmp_lt_d, cmp_eq_d;
    logic [DATAWIDTH-1:0] g_d, h_d;
    logic [DATAWIDTH-1:0] x_full_d, z_full_d;

    // Operand steering for the single add/sub unit: b for d and f, c for e.
    always_comb begin
        alu_b   = b_q;
        alu_sub = 1'b0;
        case (state_q)
            CALC_E:  alu_b   = c_q;
            CALC_F:  alu_sub = 1'b1;
            default: ;
        endcase
        alu_res_d = alu_sub ? (a_q - alu_b) : (a_q + alu_b);
    end

    assign cmp_lt_d = (d_q < e_q);
    assign cmp_eq_d = (d_q == e_q);

    assign g_d      = lt_q ? d_q : e_q;
    assign h_d      = eq_q ? g_d : f_q;

    // The shift distance is the 1-bit flag itself, so it is either 0 or 1.
    assign x_full_d = h_q << lt_q;
    assign z_full_d = g_q >> eq_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            z_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        c_q     <= bus.c;
                        busy_q  <= 1'b1;
                        state_q <= CALC_D;
                    end
                end
                CALC_D: begin
                    d_q     <= alu_res_d;
                    state_q <= CALC_E;
                end
                CALC_E: begin
                    e_q     <= alu_res_d;
                    state_q <= CALC_F;
                end
                CALC_F: begin
                    f_q     <= alu_res_d;
                    lt_q    <= cmp_lt_d;
                    eq_q    <= cmp_eq_d;
                    state_q <= SEL;
                end
                SEL: begin
                    g_q     <= g_d;
                    h_q     <= h_d;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    x_q     <= x_full_d[OUTWIDTH-1:0];
                    z_q     <= z_full_d[OUTWIDTH-1:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.x    = x_q;
    assign bus.z    = z_q;

endmodule

// File: tb/tb_c4_sched_ctrl.sv
// tb/tb_c4_sched_ctrl.sv - scoreboard bench for c4_sched_ctrl against a direct arithmetic model
module tb_c4_sched_ctrl;

    localparam int DW = 64;
    localparam int OW = 32;

    typedef struct {
        logic [OW-1:0] x;
        logic [OW-1:0] z;
        int            cyc;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    c4_sched_ctrl_if #(.DATAWIDTH(DW), .OUTWIDTH(OW)) bus ();

    c4_sched_ctrl #(.DATAWIDTH(DW), .OUTWIDTH(OW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int            cyc      = 0;
    int            busy_end = -100;
    int            checks   = 0;
    int            failures = 0;
    exp_t          sb[$];
    logic [OW-1:0] hold_x   = '0;
    logic [OW-1:0] hold_z   = '0;

    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] c, input int done_cyc);
        logic [DW-1:0] d, e, f, g, h, xs, zs;
        logic          lt, eq;
        exp_t          r;
        d  = a + b;
        e  = a + c;
        f  = a - b;
        lt = (d < e);
        eq = (d == e);
        g  = lt ? d : e;
        h  = eq ? g : f;
        xs = lt ? (h << 1) : h;
        zs = eq ? (g >> 1) : g;
        r.x   = xs[OW-1:0];
        r.z   = zs[OW-1:0];
        r.cyc = done_cyc;
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Called just after a rising edge; the request is sampled at the next edge.
    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        int e;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.c     = c;
        e = cyc + 1;
        if (e > busy_end) begin
            sb.push_back(model(a, b, c, e + 5));
            busy_end = e + 5;
        end
        @(posedge Clk); #2;
        bus.start = 1'b0;
        bus.a     = rnd64();
        bus.b     = rnd64();
        bus.c     = rnd64();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk); #2;
        end
    endtask

    task automatic do_reset(input int n);
        bus.start = 1'b0;
        Rst       = 1'b1;
        idle(n);
        sb.delete();
        busy_end = -100;
        hold_x   = '0;
        hold_z   = '0;
        Rst      = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (!Rst) begin
            logic exp_busy, exp_done;
            exp_t ent;
            exp_busy = (cyc >= busy_end - 5) && (cyc < busy_end);
            exp_done = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("busy", bus.busy, exp_busy);
            chk("done", bus.done, exp_done);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    ent = sb.pop_front();
                    chk("done_cycle", cyc, ent.cyc);
                    chk("x", bus.x, ent.x);
                    chk("z", bus.z, ent.z);
                    hold_x = ent.x;
                    hold_z = ent.z;
                end
            end else begin
                chk("x_hold", bus.x, hold_x);
                chk("z_hold", bus.z, hold_z);
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c     = '0;
        @(posedge Clk); #2;
        do_reset(2);
        idle(10);

        issue(64'd10, 64'd3, 64'd5);
        idle(8);
        issue(64'd10, 64'd5, 64'd5);
        idle(8);
        issue(64'd1, 64'd8, 64'd2);
        idle(8);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd2);
        idle(8);

        issue(64'd10, 64'd3, 64'd5);
        idle(1);
        issue(64'd7, 64'd1, 64'd9);
        issue(64'd2, 64'd2, 64'd2);
        idle(1);
        issue(64'd1, 64'd8, 64'd2);
        idle(8);

        issue(64'd10, 64'd3, 64'd5);
        idle(2);
        do_reset(1);
        idle(2);
        issue(64'd10, 64'd5, 64'd5);
        idle(8);

        for (int i = 0; i < 60; i++) begin
            logic [DW-1:0] ra, rb, rc;
            ra = rnd64();
            rb = rnd64();
            rc = rnd64();
            case ($urandom_range(0, 3))
                0: rc = rb;
                1: begin ra = DW'($urandom_range(0, 20)); rb = DW'($urandom_range(0, 20)); rc = DW'($urandom_range(0, 20)); end
                default: ;
            endcase
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 2));
            issue(ra, rb, rc);
            idle($urandom_range(0, 7));
        end

        idle(10);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
